cpu_clk_ctrl: RTL and testbench

Synchronous CPU clock-enable controller that consumes the free-running `clkdiv` counter bus from the clock divider. It turns selected counter taps into single-cycle enable pulses, applies run/pause/single-step control from board switches and a debounced step button, and drives one `cpu_ce` strobe. `cpu_ce` replaces a gated CPU clock, so the whole CPU stays on `clk`. It sits between the clock divider and the CPU/display logic on the board top level.

---
 rtl/cpu_clk_ctrl_pkg.sv | 18 +
 rtl/cpu_clk_ctrl_if.sv | 27 ++
 rtl/btn_debounce.sv | 56 +++++
 rtl/cpu_clk_ctrl.sv | 106 ++++++++++
 tb/tb_cpu_clk_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared constants for the CPU clock-enable controller: parameter defaults,
// debounce counter width and FSM state encodings.
package cpu_clk_ctrl_pkg;

   localparam int FAST_BIT_DEF = 3;
   localparam int SLOW_BIT_DEF = 24;
   localparam int DEB_BIT_DEF  = 17;
   localparam int DEB_CNT_DEF  = 4;

   localparam int DEB_W = 4;

   typedef logic [1:0] state_t;

   localparam state_t ST_RUN   = 2'd0;
   localparam state_t ST_PAUSE = 2'd1;
   localparam state_t ST_STEP  = 2'd2;

endpackage

// File: rtl/cpu_clk_ctrl_if.sv
// Board-side bundle of the clock-enable controller: divider bus and switches in,
// CPU enable strobe, status and FSM state out.
interface cpu_clk_ctrl_if;
   import cpu_clk_ctrl_pkg::*;

   // cpu_ce is a bare one-cycle strobe with no back-pressure: the CPU must
   // advance on every cycle it is high; the other inputs are levels.
   logic [31:0] clkdiv;
   logic        SW2;
   logic        SW_Pause;
   logic        BTN_Step;
   logic        cpu_ce;
   logic        paused;
   logic [31:0] instr_cnt;
   state_t      state;

   modport master (
      output clkdiv, SW2, SW_Pause, BTN_Step,
      input  cpu_ce, paused, instr_cnt, state
   );

   modport slave (
      input  clkdiv, SW2, SW_Pause, BTN_Step,
      output cpu_ce, paused, instr_cnt, state
   );

endinterface

// File: rtl/btn_debounce.sv
// Step-button debouncer: accepts a new level after DEB_CNT consecutive differing
// samples and emits a one-cycle pulse when the accepted level rises.
module btn_debounce
   import cpu_clk_ctrl_pkg::*;
#(
   parameter int DEB_CNT = DEB_CNT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic sample_tick,
   input  logic btn_s,
   output logic rise_pulse
);

   localparam logic [DEB_W-1:0] DEB_LIM = DEB_W'(DEB_CNT);

   logic [DEB_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             stable_q, stable_d;
   logic             rise_q, rise_d;

   always_comb begin
      cnt_inc  = cnt_q + 1'b1;
      cnt_d    = cnt_q;
      stable_d = stable_q;
      rise_d   = 1'b0;
      if (sample_tick) begin
         if (btn_s != stable_q) begin
            if (cnt_inc == DEB_LIM) begin
               stable_d = btn_s;
               cnt_d    = '0;
               rise_d   = btn_s;
            end else begin
               cnt_d = cnt_inc;
            end
         end else begin
            // any agreeing sample restarts the run
            cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         stable_q <= 1'b0;
         rise_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         rise_q   <= rise_d;
      end
   end

   assign rise_pulse = rise_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable controller: turns clkdiv tap edges into cpu_ce strobes under
// run/pause/single-step control from the board switches and step button.
module cpu_clk_ctrl
   import cpu_clk_ctrl_pkg::*;
#(
   parameter int FAST_BIT = FAST_BIT_DEF,
   parameter int SLOW_BIT = SLOW_BIT_DEF,
   parameter int DEB_BIT  = DEB_BIT_DEF,
   parameter int DEB_CNT  = DEB_CNT_DEF
) (
   input logic           clk,
   input logic           rst,
   cpu_clk_ctrl_if.slave bus
);

   logic [2:0]  taps, prev_q, tick;
   logic        tick_fast, tick_slow, tick_deb, sel_tick;
   logic [2:0]  sync1_q, sync2_q;
   logic        sw2_s, pause_s, btn_s;
   logic        step_req;
   state_t      state_q, state_d;
   logic        cpu_ce_q, cpu_ce_d;
   logic        paused_q;
   logic [31:0] instr_cnt_q;

   // Tap edge detect: bit 0 fast, bit 1 slow, bit 2 debounce pacing.
   assign taps = {bus.clkdiv[DEB_BIT], bus.clkdiv[SLOW_BIT], bus.clkdiv[FAST_BIT]};
   assign tick = taps & ~prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev_q <= '0;
      else     prev_q <= taps;
   end

   assign tick_fast = tick[0];
   assign tick_slow = tick[1];
   assign tick_deb  = tick[2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {bus.BTN_Step, bus.SW_Pause, bus.SW2};
         sync2_q <= sync1_q;
      end
   end

   assign sw2_s    = sync2_q[0];
   assign pause_s  = sync2_q[1];
   assign btn_s    = sync2_q[2];
   assign sel_tick = sw2_s ? tick_slow : tick_fast;

   btn_debounce #(
      .DEB_CNT (DEB_CNT)
   ) u_btn_debounce (
      .clk         (clk),
      .rst         (rst),
      .sample_tick (tick_deb),
      .btn_s       (btn_s),
      .rise_pulse  (step_req)
   );

   // A step_req arriving outside PAUSE is simply dropped.
   always_comb begin
      state_d  = state_q;
      cpu_ce_d = 1'b0;
      case (state_q)
         ST_RUN: begin
            cpu_ce_d = sel_tick & ~pause_s;
            if (pause_s) state_d = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (step_req)      state_d = ST_STEP;
            else if (!pause_s) state_d = ST_RUN;
         end
         ST_STEP: begin
            if (sel_tick) begin
               cpu_ce_d = 1'b1;
               state_d  = ST_PAUSE;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RUN;
         cpu_ce_q    <= 1'b0;
         paused_q    <= 1'b0;
         instr_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cpu_ce_q    <= cpu_ce_d;
         paused_q    <= (state_d != ST_RUN);
         instr_cnt_q <= instr_cnt_q + 32'(cpu_ce_q);
      end
   end

   assign bus.cpu_ce    = cpu_ce_q;
   assign bus.paused    = paused_q;
   assign bus.instr_cnt = instr_cnt_q;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl with FAST_BIT=3, SLOW_BIT=6, DEB_BIT=2, DEB_CNT=4.
module tb_cpu_clk_ctrl;
   import cpu_clk_ctrl_pkg::*;

   typedef struct {
      logic sw2;
      logic pause;
      int   cycles;
      int   exp_pulses;
      logic exp_paused;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   cpu_clk_ctrl_if bus ();

   cpu_clk_ctrl #(
      .FAST_BIT (3),
      .SLOW_BIT (6),
      .DEB_BIT  (2),
      .DEB_CNT  (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc_n    = 0;
   int pulse_cnt  = 0;
   int last_pulse = -1;
   int min_gap    = 1000000;
   int gap_q[$];
   logic [31:0] exp_q[$];
   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // One clock: sample outputs 1 time unit after the edge, then advance clkdiv.
   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (bus.cpu_ce === 1'b1) begin
            if (last_pulse >= 0) begin
               gap_q.push_back(cyc_n - last_pulse);
               if (cyc_n - last_pulse < min_gap) min_gap = cyc_n - last_pulse;
            end
            last_pulse = cyc_n;
            pulse_cnt++;
         end
         cyc_n++;
         bus.clkdiv = bus.clkdiv + 32'd1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int bad;
      int pc;
      int wait_n;
      logic [31:0] g;

      vecs[0] = '{sw2: 1'b0, pause: 1'b0, cycles: 64,  exp_pulses: 4, exp_paused: 1'b0};
      vecs[1] = '{sw2: 1'b1, pause: 1'b0, cycles: 256, exp_pulses: 2, exp_paused: 1'b0};
      vecs[2] = '{sw2: 1'b1, pause: 1'b1, cycles: 32,  exp_pulses: 0, exp_paused: 1'b1};
      vecs[3] = '{sw2: 1'b0, pause: 1'b1, cycles: 64,  exp_pulses: 0, exp_paused: 1'b1};
      vecs[4] = '{sw2: 1'b0, pause: 1'b0, cycles: 40,  exp_pulses: 2, exp_paused: 1'b0};

      bus.clkdiv   = 32'd0;
      bus.SW2      = 1'b0;
      bus.SW_Pause = 1'b0;
      bus.BTN_Step = 1'b0;
      #1 rst = 1'b1;

      // Reset held while clkdiv counts
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         if (bus.cpu_ce !== 1'b0 || bus.paused !== 1'b0 || bus.instr_cnt !== 32'd0) bad++;
      end
      chk("reset_outputs_zero", bad, 0);
      chk("reset_state_run", 32'(bus.state), 32'(ST_RUN));

      rst = 1'b0;
      bus.clkdiv = 32'd0;
      pulse_cnt = 0;
      last_pulse = -1;
      gap_q.delete();

      // First pulse: clkdiv=8 seen at the 9th edge
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         cyc(1);
         if (bus.cpu_ce !== 1'b0) bad++;
      end
      chk("first_pulse_not_early", bad, 0);
      cyc(1);
      chk("first_pulse", 32'(bus.cpu_ce), 32'd1);
      chk("instr_before_inc", bus.instr_cnt, 32'd0);
      cyc(1);
      chk("first_pulse_width", 32'(bus.cpu_ce), 32'd0);
      chk("instr_after_inc", bus.instr_cnt, 32'd1);

      // Fast run to 160 cycles from clkdiv=0
      cyc(150);
      chk("fast_pulses", pulse_cnt, 10);
      chk("fast_instr_cnt", bus.instr_cnt, 32'd10);
      for (int i = 0; i < 9; i++) exp_q.push_back(32'd16);
      chk("fast_gap_count", gap_q.size(), exp_q.size());
      while (exp_q.size() > 0 && gap_q.size() > 0) begin
         g = exp_q.pop_front();
         chk("fast_gap", gap_q.pop_front(), g);
      end

      // Table-driven run/pause/rate segments
      for (int i = 0; i < 5; i++) begin
         bus.SW2      = vecs[i].sw2;
         bus.SW_Pause = vecs[i].pause;
         pc = pulse_cnt;
         cyc(vecs[i].cycles);
         chk($sformatf("row%0d_pulses", i), pulse_cnt - pc, vecs[i].exp_pulses);
         chk($sformatf("row%0d_paused", i), 32'(bus.paused), 32'(vecs[i].exp_paused));
      end
      chk("table_instr_cnt", bus.instr_cnt, 32'd18);

      // Slow to fast switch right after a slow pulse
      bus.SW2 = 1'b1;
      pc = pulse_cnt;
      cyc(89);
      chk("slow_seg_pulses", pulse_cnt - pc, 2);
      bus.SW2 = 1'b0;
      pc = pulse_cnt;
      cyc(48);
      chk("switch_fast_pulses", pulse_cnt - pc, 3);
      chk("switch_first_gap", gap_q[gap_q.size() - 3], 32'd8);
      chk("no_double_pulse", 32'(min_gap >= 2), 32'd1);
      chk("switch_instr_cnt", bus.instr_cnt, 32'd23);

      // Pause
      bus.SW_Pause = 1'b1;
      pc = pulse_cnt;
      cyc(4);
      chk("paused_within_4", 32'(bus.paused), 32'd1);
      cyc(6);
      chk("pause_no_pulse", pulse_cnt - pc, 0);

      // Clean step press
      bus.BTN_Step = 1'b1;
      pc = pulse_cnt;
      cyc(100);
      chk("step_one_pulse", pulse_cnt - pc, 1);
      chk("step_instr_cnt", bus.instr_cnt, 32'd24);
      chk("step_back_pause", 32'(bus.state), 32'(ST_PAUSE));
      chk("step_paused", 32'(bus.paused), 32'd1);
      bus.BTN_Step = 1'b0;
      pc = pulse_cnt;
      cyc(60);
      chk("release_no_pulse", pulse_cnt - pc, 0);

      // Bouncing press in PAUSE
      pc = pulse_cnt;
      for (int i = 0; i < 12; i++) begin
         bus.BTN_Step = ~bus.BTN_Step;
         cyc(5);
      end
      bus.BTN_Step = 1'b1;
      cyc(100);
      chk("bounce_one_pulse", pulse_cnt - pc, 1);
      chk("bounce_instr_cnt", bus.instr_cnt, 32'd25);
      chk("bounce_state", 32'(bus.state), 32'(ST_PAUSE));
      bus.BTN_Step = 1'b0;
      cyc(60);

      // Same press while running: regular cadence, nothing queued
      bus.SW_Pause = 1'b0;
      cyc(10);
      last_pulse = -1;
      gap_q.delete();
      for (int i = 0; i < 12; i++) begin
         bus.BTN_Step = ~bus.BTN_Step;
         cyc(5);
      end
      bus.BTN_Step = 1'b1;
      cyc(100);
      bus.BTN_Step = 1'b0;
      cyc(60);
      bad = 0;
      foreach (gap_q[i]) if (gap_q[i] != 16) bad++;
      chk("run_press_gaps", bad, 0);
      chk("run_press_gap_cnt", 32'(gap_q.size() >= 12), 32'd1);
      bus.SW_Pause = 1'b1;
      cyc(4);
      pc = pulse_cnt;
      cyc(100);
      chk("run_press_not_queued", pulse_cnt - pc, 0);
      chk("run_press_paused", 32'(bus.state), 32'(ST_PAUSE));

      // Reset in the middle of a slow step
      bus.SW2 = 1'b1;
      bus.BTN_Step = 1'b1;
      pc = pulse_cnt;
      wait_n = 0;
      while (bus.state !== ST_STEP && wait_n < 300) begin
         cyc(1);
         wait_n++;
      end
      chk("enter_step", 32'(bus.state), 32'(ST_STEP));
      rst = 1'b1;
      cyc(5);
      chk("rst_step_ce", 32'(bus.cpu_ce), 32'd0);
      chk("rst_step_paused", 32'(bus.paused), 32'd0);
      chk("rst_step_instr", bus.instr_cnt, 32'd0);
      chk("rst_step_no_pulse", pulse_cnt - pc, 0);
      rst = 1'b0;
      cyc(1);
      chk("rst_step_state_run", 32'(bus.state), 32'(ST_RUN));
      chk("rst_step_paused_after", 32'(bus.paused), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
